// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared state encoding and default widths for clk_div_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_OFF   = ST_OFF,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN
    } state_t;

endpackage

`default_nettype wire

// File: rtl/clk_div_core.sv
// ============================================================================
// Module   : clk_div_core
// Brief    : Half-period counter, output toggle flop, divisor register and
//            end-of-low-phase detect for the clock divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_core #(
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             clk_out,
    output logic             boundary,
    output logic [CNT_W-1:0] cur_div
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic             out_q;
    logic             at_end;

    assign at_end   = (cnt == (div_q - ONE));
    // Raw end-of-low-phase; the controller qualifies it with the run state.
    assign boundary = !out_q && at_end;
    assign clk_out  = out_q;
    assign cur_div  = div_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            out_q <= 1'b0;
            div_q <= CNT_W'(DIV_RESET);
        end else begin
            if (load) begin
                div_q <= load_val;
            end
            if (!run) begin
                cnt   <= '0;
                out_q <= 1'b0;
            end else if (at_end) begin
                cnt   <= '0;
                out_q <= !out_q;
            end else begin
                cnt   <= cnt + ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// Module   : clk_div_ctrl
// Brief    : Glitch-free programmable clock divider: run FSM, divisor
//            handshake and pending register around clk_div_core.
//            Optional macro CLK_DIV_CTRL_TICK_EN enables the tick pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DIV_RESET = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [CNT_W-1:0] div_data,
    output logic             clk_out,
    output logic             running,
    output logic [CNT_W-1:0] cur_div,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             running_q;
    logic             pend_valid;
    logic [CNT_W-1:0] pend_div;

    logic             core_boundary;
    logic             active;
    logic             at_boundary;
    logic             stop_now;
    logic             run;
    logic             load;
    logic             xfer;

    assign active      = (state != S_OFF);
    assign at_boundary = active && core_boundary;
    // Stopping is only allowed at the end of a low phase so clk_out ends low.
    assign stop_now    = (state == S_DRAIN) && !en && at_boundary;
    assign run         = active && !stop_now;
    assign load        = pend_valid && (!active || at_boundary);
    assign xfer        = div_valid && !pend_valid;

    assign div_ready   = !pend_valid;
    assign running     = running_q;

    clk_div_core #(
        .CNT_W     (CNT_W),
        .DIV_RESET (DIV_RESET)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .load     (load),
        .load_val (pend_div),
        .clk_out  (clk_out),
        .boundary (core_boundary),
        .cur_div  (cur_div)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_OFF;
            running_q  <= 1'b0;
            pend_valid <= 1'b0;
            pend_div   <= '0;
        end else begin
            if (load) begin
                pend_valid <= 1'b0;
            end
            // A transfer needs pend_valid low, so it never collides with load;
            // a value accepted on a boundary waits for the next one.
            if (xfer) begin
                pend_valid <= 1'b1;
                pend_div   <= (div_data == '0) ? ONE : div_data;
            end

            case (state)
                S_OFF: begin
                    if (en) begin
                        state     <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (en) begin
                        state <= S_RUN;
                    end else if (at_boundary) begin
                        state     <= S_OFF;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_OFF;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_DIV_CTRL_TICK_EN
    logic tick_q;

    // A rise happens exactly when the core toggles out of a low phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= run && core_boundary;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ============================================================================
// Module   : tb_clk_div_ctrl
// Brief    : Self-checking bench for clk_div_ctrl with a phase-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_ctrl;

    localparam int CNT_W = 16;
`ifdef CLK_DIV_CTRL_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             div_valid = 1'b0;
    logic [CNT_W-1:0] div_data = '0;
    logic             div_ready;
    logic             clk_out;
    logic             running;
    logic [CNT_W-1:0] cur_div;
    logic             tick;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .CNT_W     (CNT_W),
        .DIV_RESET (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_data  (div_data),
        .clk_out   (clk_out),
        .running   (running),
        .cur_div   (cur_div),
        .tick      (tick)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Phase-level model: tracks level, cycles left in the phase and the divisor.
    bit m_on, m_drain, m_level, m_pv, m_tick;
    bit m_xfer, m_end, m_stop;
    int m_left, m_cur, m_pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on = 0; m_drain = 0; m_level = 0; m_pv = 0; m_tick = 0;
            m_left = 0; m_cur = 2; m_pend = 0;
        end else begin
            m_xfer = div_valid && !m_pv;
            m_tick = 0;
            if (!m_on) begin
                if (m_pv) begin m_cur = m_pend; m_pv = 0; end
                if (en) begin
                    m_on = 1; m_drain = 0; m_level = 0; m_left = m_cur;
                end
            end else begin
                m_left = m_left - 1;
                m_end  = (m_left == 0);
                m_stop = m_end && !m_level && m_drain && !en;
                if (m_end && !m_level && m_pv) begin m_cur = m_pend; m_pv = 0; end
                if (m_stop) begin
                    m_on = 0; m_level = 0;
                end else if (m_end) begin
                    m_level = !m_level; m_left = m_cur; m_tick = m_level;
                end
                m_drain = !en;
            end
            if (m_xfer) begin
                m_pv = 1;
                m_pend = (div_data == 0) ? 1 : int'(div_data);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("m_clk_out", 32'(clk_out), 32'(m_level));
            check("m_running", 32'(running), 32'(m_on));
            check("m_cur_div", 32'(cur_div), 32'(m_cur));
            check("m_div_ready", 32'(div_ready), 32'(!m_pv));
            check("m_tick", 32'(tick), 32'(TICK_ON & m_tick));
        end
    end

    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (clk_out !== lvl && n < 200);
    endtask

    task automatic count_same(input logic lvl, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (clk_out === lvl && n < 200) n++;
            else break;
        end
    endtask

    task automatic wait_rise_div(input int d);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(clk_out === 1'b1 && cur_div == CNT_W'(d)) && n < 300);
        check("rise_with_div", 32'(cur_div), 32'(d));
        check("rise_level", 32'(clk_out), 32'd1);
    endtask

    task automatic drain_low(output int n);
        n = 0;
        while (running === 1'b1 && clk_out === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send(input int v);
        div_valid = 1'b1;
        div_data  = CNT_W'(v);
        @(negedge clk);
        div_valid = 1'b0;
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_cur_div", 32'(cur_div), 32'd2);
        check("rst_div_ready", 32'(div_ready), 32'd1);

        // Start with the reset divisor
        rst_n = 1'b1;
        en    = 1'b1;
        wait_level(1'b1, n);
        check("first_rise_edges", 32'(n), 32'd3);
        check("first_rise_tick", 32'(tick), 32'(TICK_ON));
        check("run_running", 32'(running), 32'd1);
        count_same(1'b1, n); check("high_len_d2", 32'(n + 1), 32'd2);
        count_same(1'b0, n); check("low_len_d2", 32'(n + 1), 32'd2);

        // New divisor offered mid high phase
        send(5);
        check("ready_drop", 32'(div_ready), 32'd0);
        check("cur_div_held", 32'(cur_div), 32'd2);
        count_same(1'b1, n);
        check("cur_div_held_low", 32'(cur_div), 32'd2);
        count_same(1'b0, n);
        check("cur_div_applied", 32'(cur_div), 32'd5);
        check("ready_back", 32'(div_ready), 32'd1);
        count_same(1'b1, n); check("high_len_d5", 32'(n + 1), 32'd5);
        count_same(1'b0, n); check("low_len_d5", 32'(n + 1), 32'd5);

        // Stop, then program zero while off
        en = 1'b0;
        count_same(1'b1, n);
        drain_low(n);
        check("stop_low_len_d5", 32'(n), 32'd5);
        check("stopped", 32'(running), 32'd0);
        send(0);
        @(negedge clk);
        check("zero_maps_to_one", 32'(cur_div), 32'd1);
        en = 1'b1;
        wait_level(1'b1, n);
        check("first_rise_d1", 32'(n), 32'd2);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("toggle_d1", 32'(clk_out), 32'(i % 2 == 0));
        end

        // en dropped in the second cycle of a 4-cycle high phase
        send(4);
        wait_rise_div(4);
        @(negedge clk);
        en = 1'b0;
        count_same(1'b1, n); check("drain_high_rest", 32'(n), 32'd2);
        drain_low(n); check("drain_low_len", 32'(n), 32'd4);
        check("drain_off_running", 32'(running), 32'd0);
        repeat (3) @(negedge clk);
        check("off_clk_low", 32'(clk_out), 32'd0);

        // en re-raised during drain keeps the clock going
        en = 1'b1;
        wait_level(1'b1, n); check("restart_d4", 32'(n), 32'd5);
        @(negedge clk);
        en = 1'b0;
        count_same(1'b1, n);
        @(negedge clk);
        en = 1'b1;
        count_same(1'b0, n); check("redrain_low_rest", 32'(n), 32'd2);
        check("redrain_running", 32'(running), 32'd1);

        // Pending 7, then a transfer of 3 landing exactly on a boundary
        send(7);
        wait_rise_div(7);
        count_same(1'b1, n); check("high_len_d7", 32'(n + 1), 32'd7);
        repeat (6) @(negedge clk);
        check("bnd_low", 32'(clk_out), 32'd0);
        check("bnd_ready", 32'(div_ready), 32'd1);
        send(3);
        check("bnd_not_applied", 32'(cur_div), 32'd7);
        check("bnd_pending", 32'(div_ready), 32'd0);
        count_same(1'b1, n);
        count_same(1'b0, n);
        check("three_applied", 32'(cur_div), 32'd3);
        count_same(1'b1, n); check("high_len_d3", 32'(n + 1), 32'd3);

        // Reset pulse mid high phase
        send(6);
        wait_rise_div(6);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_clk_out", 32'(clk_out), 32'd0);
        check("mid_rst_running", 32'(running), 32'd0);
        check("mid_rst_cur_div", 32'(cur_div), 32'd2);
        check("mid_rst_ready", 32'(div_ready), 32'd1);
        check("mid_rst_tick", 32'(tick), 32'd0);
        wait_level(1'b1, n); check("post_rst_rise", 32'(n), 32'd3);
        repeat (8) @(negedge clk);
        en = 1'b0;
        n = 0;
        while (running === 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("final_stop", 32'(running), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
